// File: rtl/lfsr_rand_server_pkg.sv
// Shared definitions for the LFSR random-number server: FSM encoding,
// default feedback/initial constants and small elaboration-time helpers.
package lfsr_rand_server_pkg;

   typedef enum logic [1:0] {
      WARM  = 2'd0,
      IDLE  = 2'd1,
      STEP  = 2'd2,
      GRANT = 2'd3
   } fsm_state_t;

   localparam logic [31:0] DEFAULT_POLY = 32'h3C1835C5;
   localparam logic [31:0] DEFAULT_INIT = 32'h00000001;

   // Width needed to hold an index in [0, n-1]; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lfsr_rand_server_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
   import lfsr_rand_server_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic [NREQ-1:0] winner,
   output logic [IW-1:0]   winner_idx
);

   int j;

   // Scan from the farthest candidate down so the closest one to rr_ptr wins.
   always_comb begin
      winner     = '0;
      winner_idx = '0;
      j          = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = (int'(rr_ptr) + i) % NREQ;
         if (req[j]) begin
            winner     = '0;
            winner[j]  = 1'b1;
            winner_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/lfsr_rand_server.sv
// Shares one Galois LFSR between NREQ requesters: round-robin arbitration,
// STEPS advances per delivered word, reseeding and post-seed warm-up.
module lfsr_rand_server
   import lfsr_rand_server_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] INIT   = WIDTH'(DEFAULT_INIT),
   parameter int               NREQ   = 4,
   parameter int               STEPS  = 8,
   parameter int               WARMUP = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [WIDTH-1:0] rdata,
   input  logic             seed_valid,
   input  logic [WIDTH-1:0] seed,
   output logic             seed_ready,
   output logic             busy
);

   localparam int IW      = idx_width(NREQ);
   localparam int CNT_MAX = max_int(STEPS, WARMUP);
   localparam int CW      = idx_width(CNT_MAX + 1);
   localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP);
   localparam logic [CW-1:0] STEP_LAST = CW'(STEPS - 1);

   fsm_state_t       fsm;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_next;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    win_idx;
   logic [NREQ-1:0]  win_onehot;
   logic [IW-1:0]    arb_idx;
   logic [NREQ-1:0]  arb_onehot;
   logic [IW-1:0]    rr_ptr_next;

   assign lfsr_next   = {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? POLY : '0);
   assign rr_ptr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req        (req),
      .rr_ptr     (rr_ptr),
      .winner     (arb_onehot),
      .winner_idx (arb_idx)
   );

   // The grant is loaded on the last STEP cycle so gnt and rdata are both
   // visible while the FSM sits in GRANT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr       <= INIT;
         fsm        <= WARM;
         cnt        <= '0;
         rr_ptr     <= '0;
         win_idx    <= '0;
         win_onehot <= '0;
         gnt        <= '0;
         rdata      <= '0;
         busy       <= 1'b1;
         seed_ready <= 1'b0;
      end else begin
         case (fsm)
            WARM: begin
               if (cnt == WARM_LAST) begin
                  fsm        <= IDLE;
                  busy       <= 1'b0;
                  seed_ready <= 1'b1;
               end else begin
                  lfsr <= lfsr_next;
                  cnt  <= cnt + 1'b1;
               end
            end
            IDLE: begin
               if (seed_valid) begin
                  lfsr       <= (seed == '0) ? INIT : seed;
                  cnt        <= '0;
                  fsm        <= WARM;
                  busy       <= 1'b1;
                  seed_ready <= 1'b0;
               end else if (|req) begin
                  win_idx    <= arb_idx;
                  win_onehot <= arb_onehot;
                  cnt        <= '0;
                  fsm        <= STEP;
                  busy       <= 1'b1;
                  seed_ready <= 1'b0;
               end
            end
            STEP: begin
               lfsr <= lfsr_next;
               if (cnt == STEP_LAST) begin
                  gnt   <= win_onehot;
                  rdata <= lfsr_next;
                  fsm   <= GRANT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GRANT: begin
               gnt        <= '0;
               rr_ptr     <= rr_ptr_next;
               fsm        <= IDLE;
               busy       <= 1'b0;
               seed_ready <= 1'b1;
            end
            default: begin
               fsm <= WARM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_rand_server.sv
// Directed and randomized checks of lfsr_rand_server: one short-latency
// instance for directed vectors, one default instance for traffic.
module tb_lfsr_rand_server;

   localparam logic [31:0] POLY    = 32'h3C1835C5;
   localparam logic [31:0] INIT    = 32'h00000001;
   localparam int          B_STEPS = 8;
   localparam int          B_WARM  = 64;
   localparam int          NGRANTS = 500;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic [3:0]  req_a = '0, gnt_a;
   logic [31:0] rdata_a, seed_a = '0;
   logic        seed_valid_a = 1'b0, seed_ready_a, busy_a;

   logic [3:0]  req_b = '0, gnt_b;
   logic [31:0] rdata_b, seed_b = '0;
   logic        seed_valid_b = 1'b0, seed_ready_b, busy_b;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   lfsr_rand_server #(.WARMUP(0), .STEPS(1)) dut_a (
      .clk(clk), .reset(reset), .req(req_a), .gnt(gnt_a), .rdata(rdata_a),
      .seed_valid(seed_valid_a), .seed(seed_a), .seed_ready(seed_ready_a), .busy(busy_a)
   );

   lfsr_rand_server dut_b (
      .clk(clk), .reset(reset), .req(req_b), .gnt(gnt_b), .rdata(rdata_b),
      .seed_valid(seed_valid_b), .seed(seed_b), .seed_ready(seed_ready_b), .busy(busy_b)
   );

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? POLY : 32'h0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_gnt_a(output int cyc);
      cyc = -1;
      for (int n = 1; n <= 50 && cyc < 0; n++) begin
         tick();
         if (gnt_a !== 4'b0000) cyc = n;
      end
   endtask

   task automatic wait_seed_ready_a();
      for (int n = 0; n < 50 && seed_ready_a !== 1'b1; n++) tick();
      checks++;
      if (seed_ready_a !== 1'b1) $display("[TB] FAIL seed_ready_wait: got %b expected 1", seed_ready_a);
      else passes++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (gnt_a !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt_a); else passes++;
      checks++; if (rdata_a !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata_a); else passes++;
      checks++; if (busy_a !== 1'b1) $display("[TB] FAIL reset_busy: got %b expected 1", busy_a); else passes++;
      checks++; if (seed_ready_a !== 1'b0) $display("[TB] FAIL reset_seed_ready: got %b expected 0", seed_ready_a); else passes++;
      checks++; if (busy_b !== 1'b1) $display("[TB] FAIL reset_busy_b: got %b expected 1", busy_b); else passes++;
      reset = 1'b0;
      tick();
      checks++; if (busy_a !== 1'b0) $display("[TB] FAIL warmup0_idle_busy: got %b expected 0", busy_a); else passes++;
      checks++; if (seed_ready_a !== 1'b1) $display("[TB] FAIL warmup0_seed_ready: got %b expected 1", seed_ready_a); else passes++;
      checks++; if (busy_b !== 1'b1) $display("[TB] FAIL warmup64_busy_b: got %b expected 1", busy_b); else passes++;
   endtask

   task automatic test_single_requester();
      int cyc;
      req_a = 4'b0001;
      apply_reset();
      wait_gnt_a(cyc);
      checks++; if (cyc !== 3) $display("[TB] FAIL first_grant_latency: got %0d expected 3", cyc); else passes++;
      checks++; if (gnt_a !== 4'b0001) $display("[TB] FAIL first_grant_gnt: got %b expected 0001", gnt_a); else passes++;
      checks++; if (rdata_a !== 32'h3C1835C5) $display("[TB] FAIL first_grant_rdata: got %h expected 3c1835c5", rdata_a); else passes++;
      wait_gnt_a(cyc);
      checks++; if (cyc !== 3) $display("[TB] FAIL second_grant_period: got %0d expected 3", cyc); else passes++;
      checks++; if (rdata_a !== 32'h22142F27) $display("[TB] FAIL second_grant_rdata: got %h expected 22142f27", rdata_a); else passes++;
      req_a = 4'b0000;
      tick();
      checks++; if (rdata_a !== 32'h22142F27) $display("[TB] FAIL rdata_hold: got %h expected 22142f27", rdata_a); else passes++;
   endtask

   task automatic test_round_robin();
      int cyc;
      logic [3:0] exp_gnt;
      req_a = 4'b1111;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         wait_gnt_a(cyc);
         checks++; if (cyc !== 3) $display("[TB] FAIL rr_period_%0d: got %0d expected 3", k, cyc); else passes++;
         checks++; if (gnt_a !== exp_gnt) $display("[TB] FAIL rr_order_%0d: got %b expected %b", k, gnt_a, exp_gnt); else passes++;
      end
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_seed();
      int cyc;
      req_a = 4'b0000;
      apply_reset();
      wait_seed_ready_a();
      seed_valid_a = 1'b1;
      seed_a = 32'h2;
      tick();
      seed_valid_a = 1'b0;
      checks++; if (busy_a !== 1'b1) $display("[TB] FAIL seed_enters_warm: got %b expected 1", busy_a); else passes++;
      req_a = 4'b0010;
      wait_gnt_a(cyc);
      checks++; if (gnt_a !== 4'b0010) $display("[TB] FAIL seed2_gnt: got %b expected 0010", gnt_a); else passes++;
      checks++; if (rdata_a !== 32'h00000001) $display("[TB] FAIL seed2_rdata: got %h expected 00000001", rdata_a); else passes++;
      req_a = 4'b0000;
      wait_seed_ready_a();
      seed_valid_a = 1'b1;
      seed_a = 32'h0;
      tick();
      seed_valid_a = 1'b0;
      req_a = 4'b0010;
      wait_gnt_a(cyc);
      checks++; if (rdata_a !== 32'h3C1835C5) $display("[TB] FAIL seed0_rdata: got %h expected 3c1835c5", rdata_a); else passes++;
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_seed_priority();
      int cyc;
      req_a = 4'b0000;
      apply_reset();
      wait_seed_ready_a();
      seed_valid_a = 1'b1;
      seed_a = 32'h2;
      req_a = 4'b0100;
      tick();
      seed_valid_a = 1'b0;
      checks++; if (seed_ready_a !== 1'b0) $display("[TB] FAIL prio_left_idle: got %b expected 0", seed_ready_a); else passes++;
      tick();
      checks++; if (gnt_a !== 4'b0000) $display("[TB] FAIL prio_no_early_gnt: got %b expected 0000", gnt_a); else passes++;
      checks++; if (seed_ready_a !== 1'b1) $display("[TB] FAIL prio_back_idle: got %b expected 1", seed_ready_a); else passes++;
      wait_gnt_a(cyc);
      checks++; if (gnt_a !== 4'b0100) $display("[TB] FAIL prio_gnt: got %b expected 0100", gnt_a); else passes++;
      checks++; if (rdata_a !== 32'h00000001) $display("[TB] FAIL prio_rdata: got %h expected 00000001", rdata_a); else passes++;
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_step();
      int cyc;
      req_a = 4'b0100;
      apply_reset();
      wait_gnt_a(cyc);
      checks++; if (rdata_a !== 32'h3C1835C5) $display("[TB] FAIL mid_pre_rdata: got %h expected 3c1835c5", rdata_a); else passes++;
      tick();
      tick();
      checks++; if (busy_a !== 1'b1) $display("[TB] FAIL mid_in_step: got %b expected 1", busy_a); else passes++;
      reset = 1'b1;
      #1;
      checks++; if (gnt_a !== 4'b0000) $display("[TB] FAIL mid_reset_gnt: got %b expected 0000", gnt_a); else passes++;
      checks++; if (busy_a !== 1'b1) $display("[TB] FAIL mid_reset_busy: got %b expected 1", busy_a); else passes++;
      checks++; if (rdata_a !== 32'h0) $display("[TB] FAIL mid_reset_rdata: got %h expected 00000000", rdata_a); else passes++;
      tick();
      checks++; if (gnt_a !== 4'b0000) $display("[TB] FAIL mid_reset_dropped: got %b expected 0000", gnt_a); else passes++;
      reset = 1'b0;
      wait_gnt_a(cyc);
      checks++; if (cyc !== 3) $display("[TB] FAIL mid_after_latency: got %0d expected 3", cyc); else passes++;
      checks++; if (gnt_a !== 4'b0100) $display("[TB] FAIL mid_after_gnt: got %b expected 0100", gnt_a); else passes++;
      checks++; if (rdata_a !== 32'h3C1835C5) $display("[TB] FAIL mid_after_rdata: got %h expected 3c1835c5", rdata_a); else passes++;
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_random_traffic();
      logic [31:0] model;
      int waits[4];
      int extra[4];
      int grants, cycles, warm_left, bound;
      logic drop_seed;
      req_b = 4'b0000;
      seed_valid_b = 1'b0;
      apply_reset();
      model = INIT;
      for (int s = 0; s < B_WARM; s++) model = lfsr_step(model);
      for (int i = 0; i < 4; i++) begin waits[i] = 0; extra[i] = 0; end
      grants = 0;
      cycles = 0;
      drop_seed = 1'b0;
      warm_left = B_WARM + 2;
      while (grants < NGRANTS && cycles < 40000) begin
         if (gnt_b !== 4'b0000) begin
            for (int s = 0; s < B_STEPS; s++) model = lfsr_step(model);
            checks++; if (!$onehot(gnt_b)) $display("[TB] FAIL rand_onehot: got %b expected one-hot", gnt_b); else passes++;
            checks++; if ((gnt_b & ~req_b) !== 4'b0000) $display("[TB] FAIL rand_unrequested: gnt %b req %b expected gnt within req", gnt_b, req_b); else passes++;
            checks++; if (rdata_b === 32'h0) $display("[TB] FAIL rand_zero: got %h expected nonzero", rdata_b); else passes++;
            checks++; if (rdata_b !== model) $display("[TB] FAIL rand_rdata: got %h expected %h", rdata_b, model); else passes++;
            for (int i = 0; i < 4; i++) begin
               if (gnt_b[i]) begin
                  bound = 4 * (B_STEPS + 2) + 2 + extra[i];
                  checks++; if (waits[i] > bound) $display("[TB] FAIL rand_latency_%0d: got %0d expected <= %0d", i, waits[i], bound); else passes++;
                  req_b[i] = 1'b0;
               end
            end
            grants++;
         end
         for (int i = 0; i < 4; i++) begin
            if (!req_b[i] && $urandom_range(3) == 0) begin
               req_b[i] = 1'b1;
               waits[i] = 0;
               extra[i] = warm_left;
            end
         end
         if (drop_seed) begin
            seed_valid_b = 1'b0;
            drop_seed = 1'b0;
         end else if (!seed_valid_b && $urandom_range(127) == 0) begin
            seed_valid_b = 1'b1;
            seed_b = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom);
         end
         if (seed_valid_b && seed_ready_b && !drop_seed) begin
            model = (seed_b == 32'h0) ? INIT : seed_b;
            for (int s = 0; s < B_WARM; s++) model = lfsr_step(model);
            for (int i = 0; i < 4; i++) if (req_b[i]) extra[i] += B_WARM + 2;
            warm_left = B_WARM + 2;
            drop_seed = 1'b1;
         end
         for (int i = 0; i < 4; i++) if (req_b[i]) waits[i]++;
         if (warm_left > 0) warm_left--;
         tick();
         cycles++;
      end
      checks++;
      if (grants < NGRANTS) $display("[TB] FAIL rand_timeout: got %0d grants expected %0d", grants, NGRANTS);
      else passes++;
      req_b = 4'b0000;
      seed_valid_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_requester();
      test_round_robin();
      test_seed();
      test_seed_priority();
      test_reset_mid_step();
      test_random_traffic();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
